// File: rtl/divider_pkg.sv
// Shared types and helpers for the even-ratio clock divider controller.
package divider_pkg;

  localparam int unsigned RATIO_W_DEFAULT = 8;
  localparam int unsigned MIN_RATIO       = 2;

  typedef enum logic [1:0] {StIdle, StRun, StPend, StDrain} state_e;

  function automatic logic ratio_legal(input logic [31:0] ratio);
    return (ratio[0] == 1'b0) && (ratio >= MIN_RATIO);
  endfunction

endpackage

// File: rtl/divider_core.sv
// Half-period counter producing the divided clock, its rising tick and the period-end strobe.
module divider_core #(
  parameter int unsigned HALF_W       = 7,
  parameter int unsigned DEFAULT_HALF = 3
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              run,
  input  logic              restart,
  input  logic              load,
  input  logic [HALF_W-1:0] load_half,
  output logic              clk_out,
  output logic              div_tick,
  output logic              period_end
);

  logic [HALF_W-1:0] half_q;
  logic [HALF_W-1:0] cnt_q;
  logic              clk_q;
  logic              tick_q;
  logic              wrap;

  assign wrap       = run && (cnt_q == (half_q - HALF_W'(1)));
  // The 1->0 toggle closes a full output period.
  assign period_end = wrap && clk_q;
  assign clk_out    = clk_q;
  assign div_tick   = tick_q;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      half_q <= HALF_W'(DEFAULT_HALF);
      cnt_q  <= '0;
      clk_q  <= 1'b0;
      tick_q <= 1'b0;
    end else begin
      if (load) begin
        half_q <= load_half;
      end
      if (restart || !run) begin
        cnt_q  <= '0;
        clk_q  <= 1'b0;
        tick_q <= 1'b0;
      end else if (wrap) begin
        cnt_q  <= '0;
        clk_q  <= ~clk_q;
        tick_q <= ~clk_q;
      end else begin
        cnt_q  <= cnt_q + HALF_W'(1);
        tick_q <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/divider_ctrl.sv
// Ratio-change handshake, legality check and run/stop sequencing for the clock divider.
module divider_ctrl
  import divider_pkg::*;
#(
  parameter int unsigned RATIO_W       = RATIO_W_DEFAULT,
  parameter int unsigned DEFAULT_RATIO = 6
) (
  input  logic               sys_clk,
  input  logic               sys_rst_n,
  input  logic               en,
  input  logic               cfg_valid,
  input  logic [RATIO_W-1:0] cfg_ratio,
  output logic               cfg_ready,
  output logic               cfg_err,
  output logic               clk_out,
  output logic               div_tick,
  output logic               busy
);

  localparam int unsigned HalfW = RATIO_W - 1;

  state_e           state_q, state_d;
  logic [HalfW-1:0] pend_half_q, pend_half_d;
  logic [HalfW-1:0] load_half;
  logic             has_pend_q, has_pend_d;
  logic             err_q, err_d;
  logic             accept, accept_legal;
  logic             load, period_end;

  assign accept       = cfg_valid && cfg_ready;
  assign accept_legal = accept && ratio_legal(32'(cfg_ratio));
  assign cfg_ready    = ~has_pend_q;
  assign cfg_err      = err_q;
  assign busy         = (state_q != StIdle);

  always_comb begin
    state_d     = state_q;
    pend_half_d = pend_half_q;
    has_pend_d  = has_pend_q;
    load        = 1'b0;
    load_half   = pend_half_q;
    err_d       = accept && !accept_legal;

    if (state_q == StIdle) begin
      if (accept_legal) begin
        load      = 1'b1;
        load_half = cfg_ratio[RATIO_W-1:1];
      end
      if (en) begin
        state_d = StRun;
      end
    end else begin
      if (accept_legal) begin
        pend_half_d = cfg_ratio[RATIO_W-1:1];
        has_pend_d  = 1'b1;
      end
      // A new ratio only ever takes effect on a period boundary.
      if (period_end) begin
        if (has_pend_q) begin
          load       = 1'b1;
          has_pend_d = 1'b0;
        end else if (accept_legal && (state_q == StDrain)) begin
          load       = 1'b1;
          load_half  = cfg_ratio[RATIO_W-1:1];
          has_pend_d = 1'b0;
        end
      end
      unique case (state_q)
        StRun: begin
          if (!en) state_d = StDrain;
          else if (has_pend_d) state_d = StPend;
        end
        StPend: begin
          if (!en) state_d = StDrain;
          else if (!has_pend_d) state_d = StRun;
        end
        StDrain: begin
          if (period_end) state_d = en ? StRun : StIdle;
          else if (en) state_d = has_pend_d ? StPend : StRun;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q     <= StIdle;
      pend_half_q <= '0;
      has_pend_q  <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      pend_half_q <= pend_half_d;
      has_pend_q  <= has_pend_d;
      err_q       <= err_d;
    end
  end

  divider_core #(
    .HALF_W       (HalfW),
    .DEFAULT_HALF (DEFAULT_RATIO / 2)
  ) u_core (
    .sys_clk    (sys_clk),
    .sys_rst_n  (sys_rst_n),
    .run        (busy),
    .restart    (!busy),
    .load       (load),
    .load_half  (load_half),
    .clk_out    (clk_out),
    .div_tick   (div_tick),
    .period_end (period_end)
  );

endmodule

// File: tb/tb_divider_ctrl.sv
// Directed and randomized checks of divider_ctrl against a period-position reference model.
module tb_divider_ctrl;

  localparam int RW  = 8;
  localparam int DEF = 6;

  logic          sys_clk = 1'b0;
  logic          sys_rst_n;
  logic          en;
  logic          cfg_valid;
  logic [RW-1:0] cfg_ratio;
  logic          cfg_ready;
  logic          cfg_err;
  logic          clk_out;
  logic          div_tick;
  logic          busy;

  always #5 sys_clk = ~sys_clk;

  divider_ctrl #(
    .RATIO_W       (RW),
    .DEFAULT_RATIO (DEF)
  ) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .en        (en),
    .cfg_valid (cfg_valid),
    .cfg_ratio (cfg_ratio),
    .cfg_ready (cfg_ready),
    .cfg_err   (cfg_err),
    .clk_out   (clk_out),
    .div_tick  (div_tick),
    .busy      (busy)
  );

  int n_vec = 0;
  int n_err = 0;

  // Model: position inside the current output period plus run/stop/pending flags.
  bit m_run, m_stop, m_pv, m_err;
  int m_ratio, m_pend, m_pos;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_run   = 1'b0;
    m_stop  = 1'b0;
    m_pv    = 1'b0;
    m_err   = 1'b0;
    m_ratio = DEF;
    m_pend  = 0;
    m_pos   = 0;
  endfunction

  function automatic void model_step(input bit e, input bit v, input int r);
    bit acc, legal, accl;
    acc   = v && !m_pv;
    legal = (r % 2 == 0) && (r >= 2);
    accl  = acc && legal;
    m_err = acc && !legal;
    if (!m_run) begin
      if (accl) m_ratio = r;
      m_pos = 0;
      if (e) begin
        m_run  = 1'b1;
        m_stop = 1'b0;
      end
    end else if (m_pos == m_ratio - 1) begin
      m_pos = 0;
      if (m_pv) begin
        m_ratio = m_pend;
        m_pv    = 1'b0;
      end else if (accl) begin
        if (m_stop) m_ratio = r;
        else begin
          m_pv   = 1'b1;
          m_pend = r;
        end
      end
      if (m_stop) begin
        if (e) m_stop = 1'b0;
        else m_run = 1'b0;
      end else if (!e) begin
        m_stop = 1'b1;
      end
    end else begin
      m_pos++;
      if (accl) begin
        m_pv   = 1'b1;
        m_pend = r;
      end
      m_stop = !e;
    end
  endfunction

  task automatic compare();
    check_eq("clk_out", 32'(clk_out), 32'(m_run && (m_pos >= m_ratio / 2)));
    check_eq("div_tick", 32'(div_tick), 32'(m_run && (m_pos == m_ratio / 2)));
    check_eq("busy", 32'(busy), 32'(m_run));
    check_eq("cfg_ready", 32'(cfg_ready), 32'(!m_pv));
    check_eq("cfg_err", 32'(cfg_err), 32'(m_err));
  endtask

  task automatic cycle(input bit e, input bit v, input int r);
    en        = e;
    cfg_valid = v;
    cfg_ratio = RW'(r);
    @(posedge sys_clk);
    model_step(e, v, r);
    @(negedge sys_clk);
    compare();
  endtask

  task automatic do_reset();
    sys_rst_n = 1'b0;
    model_reset();
    #1;
    compare();
    @(negedge sys_clk);
    compare();
    sys_rst_n = 1'b1;
  endtask

  initial begin
    bit e;
    int r;
    sys_rst_n = 1'b0;
    en        = 1'b0;
    cfg_valid = 1'b0;
    cfg_ratio = '0;
    model_reset();
    repeat (2) @(negedge sys_clk);
    compare();
    sys_rst_n = 1'b1;

    // Run at the default ratio.
    repeat (16) cycle(1'b1, 1'b0, 0);
    // Illegal requests: odd, zero, one.
    cycle(1'b1, 1'b1, 7);
    cycle(1'b1, 1'b0, 0);
    cycle(1'b1, 1'b1, 0);
    cycle(1'b1, 1'b0, 0);
    cycle(1'b1, 1'b1, 1);
    repeat (2) cycle(1'b1, 1'b0, 0);
    // Ratio change while running.
    cycle(1'b1, 1'b1, 10);
    repeat (24) cycle(1'b1, 1'b0, 0);
    // Stop and drain to idle.
    repeat (22) cycle(1'b0, 1'b0, 0);
    // Same-edge accept and enable from idle.
    cycle(1'b1, 1'b1, 4);
    repeat (12) cycle(1'b1, 1'b0, 0);
    // Reset while a ratio is pending.
    cycle(1'b1, 1'b1, 10);
    cycle(1'b1, 1'b0, 0);
    check_eq("pend_before_reset", 32'(cfg_ready), 32'(0));
    do_reset();
    repeat (14) cycle(1'b1, 1'b0, 0);

    // Randomized traffic.
    e = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(39) == 0) e = !e;
      case ($urandom_range(7))
        6:       r = 2;
        7:       r = int'($urandom_range(255));
        default: r = int'($urandom_range(11));
      endcase
      cycle(e, $urandom_range(7) == 0, r);
      if ($urandom_range(599) == 0) do_reset();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
